cmp_pair_gen: RTL and testbench

- Inverse of the magnitude comparator. The block takes a requested relation (A>B, A=B, A<B) and enumerates, in ascending order, every WIDTH-bit operand pair (A,B) that satisfies it.
- Each pair is emitted over a valid/ready stream.
- Used as the operand source for comparator exercise and self-test paths, and as a relation-to-operands decoder feeding downstream datapaths.

---
 rtl/cmp_pair_gen_pkg.sv | 21 ++
 rtl/cmp_pair_gen_mag_cmp_w.sv | 16 +
 rtl/cmp_pair_gen.sv | 155 +++++++++++++++
 tb/tb_cmp_pair_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pair_gen_pkg.sv
// Shared types and helpers for the relation-to-operand-pair generator.
package cmp_pair_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned REL_W  = 3;
    localparam int unsigned REL_GT = 2;
    localparam int unsigned REL_EQ = 1;
    localparam int unsigned REL_LT = 0;

    // True when exactly one relation bit is requested.
    function automatic logic onehot3(input logic [REL_W-1:0] rel);
        return (rel == 3'b001) || (rel == 3'b010) || (rel == 3'b100);
    endfunction

endpackage

// File: rtl/cmp_pair_gen_mag_cmp_w.sv
// Combinational WIDTH-bit magnitude comparator; flags follow the rel bit order.
module mag_cmp_w #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_gt_c,
    output logic             o_eq_c,
    output logic             o_lt_c
);

    assign o_gt_c = (i_a >  i_b);
    assign o_eq_c = (i_a == i_b);
    assign o_lt_c = (i_a <  i_b);

endmodule

// File: rtl/cmp_pair_gen.sv
// Enumerates every WIDTH-bit (A,B) pair satisfying a requested relation, a-major order.
// Optional abort input enabled by defining CMP_PAIR_GEN_ABORT_EN.
module cmp_pair_gen
    import cmp_pair_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         rel,
`ifdef CMP_PAIR_GEN_ABORT_EN
    input  logic               abort,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2*WIDTH-1:0] count
);

    localparam int unsigned IDX_W = 2 * WIDTH;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_count;
    logic [2:0]         r_rel_q;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_a;
    logic [WIDTH-1:0]   r_out_b;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [WIDTH-1:0]   w_cand_a;
    logic [WIDTH-1:0]   w_cand_b;
    logic               w_gt;
    logic               w_eq;
    logic               w_lt;
    logic               w_match;
    logic               w_last;
    logic               w_hs;
    logic               w_abort;

    assign w_cand_a = r_idx[IDX_W-1:WIDTH];
    assign w_cand_b = r_idx[WIDTH-1:0];

    mag_cmp_w #(.WIDTH(WIDTH)) u_cmp (
        .i_a    (w_cand_a),
        .i_b    (w_cand_b),
        .o_gt_c (w_gt),
        .o_eq_c (w_eq),
        .o_lt_c (w_lt)
    );

    assign w_match = |(r_rel_q & {w_gt, w_eq, w_lt});
    assign w_last  = (r_idx == {IDX_W{1'b1}});
    assign w_hs    = r_out_valid & out_ready;

`ifdef CMP_PAIR_GEN_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            r_rel_q     <= '0;
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (onehot3(rel)) begin
                            r_rel_q <= rel;
                            r_idx   <= '0;
                            r_count <= '0;
                            r_busy  <= 1'b1;
                            r_state <= SCAN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (w_abort) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_match) begin
                        r_out_a     <= w_cand_a;
                        r_out_b     <= w_cand_b;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (w_hs) begin
                        r_count <= r_count + IDX_W'(1);
                    end
                    // Terminal check precedes the increment so idx never wraps.
                    if (w_abort) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_hs) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign count     = r_count;

endmodule

// File: tb/tb_cmp_pair_gen.sv
// Directed self-checking bench for cmp_pair_gen at WIDTH=2.
// Abort scenario is exercised when CMP_PAIR_GEN_ABORT_EN is defined.
module tb_cmp_pair_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] rel;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_a;
    logic [1:0] out_b;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] count;
`ifdef CMP_PAIR_GEN_ABORT_EN
    logic       abort;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int exp_a[6];
    int exp_b[6];

    always #5 clk = ~clk;

    cmp_pair_gen #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rel       (rel),
`ifdef CMP_PAIR_GEN_ABORT_EN
        .abort     (abort),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int cnt = 0;
        while (out_valid !== 1'b1 && cnt < 64) begin
            tick();
            cnt++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    // Accepts pairs k0..n-1 from exp_a/exp_b with out_ready high, then checks the done pulse.
    task automatic collect(input string tag, input int k0, input int n, input int exp_cnt);
        int cnt = 0;
        for (int k = k0; k < n; k++) begin
            wait_valid({tag, "_valid"});
            check({tag, "_a"}, 32'(out_a), 32'(exp_a[k]));
            check({tag, "_b"}, 32'(out_b), 32'(exp_b[k]));
            tick();
        end
        while (done !== 1'b1 && cnt < 64) begin
            check({tag, "_no_extra_valid"}, 32'(out_valid), 32'd0);
            tick();
            cnt++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_count"}, 32'(count), 32'(exp_cnt));
        tick();
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        rel       = 3'b000;
        out_ready = 1'b1;
`ifdef CMP_PAIR_GEN_ABORT_EN
        abort     = 1'b0;
`endif
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_count", 32'(count),     32'd0);
        check("rst_a",     32'(out_a),     32'd0);
        rst = 1'b0;
        tick();

        // Equality run with latency checks on the first pair.
        exp_a = '{0, 1, 2, 3, 0, 0};
        exp_b = '{0, 1, 2, 3, 0, 0};
        start = 1'b1; rel = 3'b010;
        tick();
        start = 1'b0;
        check("eq_busy_rise", 32'(busy),      32'd1);
        check("eq_valid_lat", 32'(out_valid), 32'd0);
        tick();
        check("eq_first_valid", 32'(out_valid), 32'd1);
        collect("eq", 0, 4, 4);

        // Invalid relation requests.
        start = 1'b1; rel = 3'b011;
        tick();
        start = 1'b0;
        check("err011_pulse", 32'(err),  32'd1);
        check("err011_busy",  32'(busy), 32'd0);
        tick();
        check("err011_1cyc",  32'(err),  32'd0);
        check("err011_count", 32'(count), 32'd4);
        start = 1'b1; rel = 3'b000;
        tick();
        start = 1'b0;
        check("err000_pulse", 32'(err),  32'd1);
        check("err000_busy",  32'(busy), 32'd0);
        tick();
        check("err000_1cyc",  32'(err),  32'd0);

        // Greater-than run; start held with a different rel while busy must be ignored.
        exp_a = '{1, 2, 2, 3, 3, 3};
        exp_b = '{0, 0, 1, 0, 1, 2};
        start = 1'b1; rel = 3'b100;
        tick();
        rel = 3'b011;
        for (int i = 0; i < 3; i++) begin
            check("busy_start_err", 32'(err),  32'd0);
            check("busy_start_bsy", 32'(busy), 32'd1);
            tick();
        end
        start = 1'b0;
        collect("gt", 0, 6, 6);

        // Less-than run.
        exp_a = '{0, 0, 0, 1, 1, 2};
        exp_b = '{1, 2, 3, 2, 3, 3};
        start = 1'b1; rel = 3'b001;
        tick();
        start = 1'b0;
        collect("lt", 0, 6, 6);

        // Backpressure on the second equality pair.
        exp_a = '{0, 1, 2, 3, 0, 0};
        exp_b = '{0, 1, 2, 3, 0, 0};
        start = 1'b1; rel = 3'b010;
        tick();
        start = 1'b0;
        wait_valid("bp_first");
        check("bp_first_a", 32'(out_a), 32'd0);
        tick();
        out_ready = 1'b0;
        wait_valid("bp_second");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_a",     32'(out_a),     32'd1);
            check("bp_hold_b",     32'(out_b),     32'd1);
        end
        out_ready = 1'b1;
        collect("bp", 1, 4, 4);

        // Reset while holding (2,1) in a greater-than run.
        start = 1'b1; rel = 3'b100;
        tick();
        start = 1'b0;
        wait_valid("rh_p1");
        check("rh_p1_a", 32'(out_a), 32'd1);
        tick();
        wait_valid("rh_p2");
        check("rh_p2_b", 32'(out_b), 32'd0);
        tick();
        out_ready = 1'b0;
        wait_valid("rh_p3");
        check("rh_p3_a", 32'(out_a), 32'd2);
        check("rh_p3_b", 32'(out_b), 32'd1);
        rst = 1'b1;
        tick();
        check("rh_valid", 32'(out_valid), 32'd0);
        check("rh_a",     32'(out_a),     32'd0);
        check("rh_b",     32'(out_b),     32'd0);
        check("rh_busy",  32'(busy),      32'd0);
        check("rh_done",  32'(done),      32'd0);
        check("rh_count", 32'(count),     32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rh_no_done", 32'(done), 32'd0);
        check("rh_idle",    32'(busy), 32'd0);

`ifdef CMP_PAIR_GEN_ABORT_EN
        // Abort right after the second accepted greater-than pair.
        start = 1'b1; rel = 3'b100;
        tick();
        start = 1'b0;
        wait_valid("ab_p1");
        tick();
        wait_valid("ab_p2");
        check("ab_p2_a", 32'(out_a), 32'd2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_valid", 32'(out_valid), 32'd0);
        check("ab_done",  32'(done),      32'd1);
        check("ab_count", 32'(count),     32'd2);
        tick();
        check("ab_busy",  32'(busy),      32'd0);
        check("ab_done1", 32'(done),      32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
